cmos_pixel_capture: RTL and testbench

Camera-side capture stage between the OV5640 8-bit parallel bus and the video frame buffer write port. Pairs bytes into 16-bit RGB565 words, reorders the colour fields into frame-buffer `{r,g,b}` order, and drops the first frames after sensor configuration. It emits only whole frames, and publishes per-frame geometry statistics for debug on the PMOD/UART path.

---
 rtl/cmos_pixel_capture.sv | 234 +++++++++++++++++++++++
 tb/tb_cmos_pixel_capture.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_pixel_capture.sv
// OV5640 8-bit parallel capture: pairs bytes into RGB565 words, drops start-up frames,
// streams only whole frames and publishes per-frame geometry for debug.
module cmos_pixel_capture #(
  parameter int unsigned FRAME_SKIP = 10,
  parameter int unsigned H_PIXELS   = 640,
  parameter int unsigned V_LINES    = 480,
  parameter bit          SWAP_RB    = 1'b1
) (
  input  logic        cmos_pclk,
  input  logic        I_rst_n,
  input  logic        I_cfg_done,
  input  logic        I_vsync,
  input  logic        I_href,
  input  logic [7:0]  I_data,
  output logic        O_vs_n,
  output logic        O_de,
  output logic [15:0] O_data,
  output logic        O_streaming,
  output logic [11:0] O_pix_cnt,
  output logic [11:0] O_line_cnt,
  output logic [15:0] O_frame_cnt,
  output logic        O_size_ok,
  output logic        O_odd_err
);

  localparam logic [15:0] SkipN = 16'(FRAME_SKIP);
  localparam logic [11:0] HPix  = 12'(H_PIXELS);
  localparam logic [11:0] VLin  = 12'(V_LINES);
  localparam logic [11:0] CntMax = 12'hFFF;

  typedef enum logic [1:0] {StWaitCfg, StSkip, StArm, StStream} state_e;

  state_e      state_q, state_d;
  logic        cfg_meta_q, cfg_sync_q;
  logic        vsync_q, href_q, vsync_p_q, href_p_q;
  logic [7:0]  data_q;
  logic [15:0] skip_cnt_q, skip_cnt_d;

  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] word_q, word_d;
  logic        wvalid_q, wvalid_d;

  logic        fall_q, fall_d, rise_q, rise_d, line_odd_q, line_odd_d;
  logic [11:0] line_pix_q, line_pix_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic        frame_ok_q, frame_ok_d;

  logic        vs_dly_q, vs_dly_d;
  logic        vs_n_q, vs_n_d;
  logic        de_q, de_d;
  logic [15:0] data_out_q, data_out_d;
  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic [11:0] line_out_q, line_out_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        size_ok_q, size_ok_d;
  logic        odd_err_q, odd_err_d;

  logic        v_rise, v_fall, h_fall, active, odd_now;
  logic [11:0] lines_now;
  logic        ok_now;
  logic [15:0] word_swz;

  assign v_rise  = vsync_q & ~vsync_p_q;
  assign v_fall  = ~vsync_q & vsync_p_q;
  assign h_fall  = ~href_q & href_p_q;
  // Losing cfg_done takes effect on the same edge the FSM leaves STREAM.
  assign active  = (state_q == StStream) && cfg_sync_q;
  assign odd_now = active && h_fall && phase_q;

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    if (!cfg_sync_q) begin
      state_d    = StWaitCfg;
      skip_cnt_d = '0;
    end else begin
      unique case (state_q)
        StWaitCfg: begin
          skip_cnt_d = '0;
          state_d    = (SkipN == 16'd0) ? StArm : StSkip;
        end
        StSkip: begin
          if (v_rise) begin
            skip_cnt_d = skip_cnt_q + 16'd1;
            if (skip_cnt_d == SkipN) state_d = StArm;
          end
        end
        StArm: begin
          if (v_fall) state_d = StStream;
        end
        StStream: state_d = StStream;
        default:  state_d = StWaitCfg;
      endcase
    end
  end

  always_comb begin
    phase_d  = phase_q;
    hi_d     = hi_q;
    word_d   = word_q;
    wvalid_d = 1'b0;
    if (!active || !href_q) begin
      phase_d = 1'b0;
    end else if (!phase_q) begin
      hi_d    = data_q;
      phase_d = 1'b1;
    end else begin
      word_d   = {hi_q, data_q};
      wvalid_d = 1'b1;
      phase_d  = 1'b0;
    end
    fall_d     = active && h_fall;
    rise_d     = active && v_rise;
    line_odd_d = odd_now;
  end

  // Line close is folded in before frame close so coincident edges count the last line.
  always_comb begin
    line_pix_d  = line_pix_q;
    line_cnt_d  = line_cnt_q;
    frame_ok_d  = frame_ok_q;
    pix_cnt_d   = pix_cnt_q;
    line_out_d  = line_out_q;
    frame_cnt_d = frame_cnt_q;
    size_ok_d   = size_ok_q;
    lines_now   = line_cnt_q;
    ok_now      = frame_ok_q;
    if (!active) begin
      line_pix_d = '0;
      line_cnt_d = '0;
      frame_ok_d = 1'b1;
    end else begin
      if (wvalid_q && (line_pix_q != CntMax)) line_pix_d = line_pix_q + 12'd1;
      if (fall_q) begin
        pix_cnt_d  = line_pix_q;
        line_pix_d = wvalid_q ? 12'd1 : 12'd0;
        ok_now     = frame_ok_q && (line_pix_q == HPix) && !line_odd_q;
        lines_now  = (line_cnt_q == CntMax) ? line_cnt_q : line_cnt_q + 12'd1;
        line_cnt_d = lines_now;
        frame_ok_d = ok_now;
      end
      if (rise_q) begin
        line_out_d  = lines_now;
        frame_cnt_d = frame_cnt_q + 16'd1;
        size_ok_d   = (lines_now == VLin) && ok_now;
        line_cnt_d  = '0;
        frame_ok_d  = 1'b1;
      end
    end
  end

  always_comb begin
    word_swz   = SWAP_RB ? {word_q[4:0], word_q[10:5], word_q[15:11]} : word_q;
    de_d       = wvalid_q && active;
    data_out_d = de_d ? word_swz : data_out_q;
    vs_dly_d   = vsync_q;
    vs_n_d     = active ? ~vs_dly_q : 1'b1;
    odd_err_d  = odd_err_q | odd_now;
  end

  always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= StWaitCfg;
      cfg_meta_q  <= 1'b0;
      cfg_sync_q  <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= '0;
      vsync_p_q   <= 1'b0;
      href_p_q    <= 1'b0;
      skip_cnt_q  <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      word_q      <= '0;
      wvalid_q    <= 1'b0;
      fall_q      <= 1'b0;
      rise_q      <= 1'b0;
      line_odd_q  <= 1'b0;
      line_pix_q  <= '0;
      line_cnt_q  <= '0;
      frame_ok_q  <= 1'b1;
      vs_dly_q    <= 1'b0;
      vs_n_q      <= 1'b1;
      de_q        <= 1'b0;
      data_out_q  <= '0;
      pix_cnt_q   <= '0;
      line_out_q  <= '0;
      frame_cnt_q <= '0;
      size_ok_q   <= 1'b0;
      odd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_meta_q  <= I_cfg_done;
      cfg_sync_q  <= cfg_meta_q;
      vsync_q     <= I_vsync;
      href_q      <= I_href;
      data_q      <= I_data;
      vsync_p_q   <= vsync_q;
      href_p_q    <= href_q;
      skip_cnt_q  <= skip_cnt_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      word_q      <= word_d;
      wvalid_q    <= wvalid_d;
      fall_q      <= fall_d;
      rise_q      <= rise_d;
      line_odd_q  <= line_odd_d;
      line_pix_q  <= line_pix_d;
      line_cnt_q  <= line_cnt_d;
      frame_ok_q  <= frame_ok_d;
      vs_dly_q    <= vs_dly_d;
      vs_n_q      <= vs_n_d;
      de_q        <= de_d;
      data_out_q  <= data_out_d;
      pix_cnt_q   <= pix_cnt_d;
      line_out_q  <= line_out_d;
      frame_cnt_q <= frame_cnt_d;
      size_ok_q   <= size_ok_d;
      odd_err_q   <= odd_err_d;
    end
  end

  assign O_vs_n      = vs_n_q;
  assign O_de        = de_q;
  assign O_data      = data_out_q;
  assign O_streaming = (state_q == StStream);
  assign O_pix_cnt   = pix_cnt_q;
  assign O_line_cnt  = line_out_q;
  assign O_frame_cnt = frame_cnt_q;
  assign O_size_ok   = size_ok_q;
  assign O_odd_err   = odd_err_q;

endmodule

// File: tb/tb_cmos_pixel_capture.sv
// Directed bench for cmos_pixel_capture on a scaled 4x3 frame geometry with two skipped frames.
module tb_cmos_pixel_capture;

  logic        clk, rst_n, cfg_done, vsync, href;
  logic [7:0]  data;
  logic        o_vs_n, o_de, o_str, o_ok, o_odd;
  logic [15:0] o_data, o_frame;
  logic [11:0] o_pix, o_line;
  logic        o_vs_n0, o_de0, o_str0, o_ok0, o_odd0;
  logic [15:0] o_data0, o_frame0;
  logic [11:0] o_pix0, o_line0;

  int n_checks = 0;
  int n_fail   = 0;
  int de_count = 0;
  int consec   = 0;
  logic de_prev = 1'b0;

  cmos_pixel_capture #(
    .FRAME_SKIP(2), .H_PIXELS(4), .V_LINES(3), .SWAP_RB(1'b1)
  ) dut (
    .cmos_pclk(clk), .I_rst_n(rst_n), .I_cfg_done(cfg_done), .I_vsync(vsync),
    .I_href(href), .I_data(data), .O_vs_n(o_vs_n), .O_de(o_de), .O_data(o_data),
    .O_streaming(o_str), .O_pix_cnt(o_pix), .O_line_cnt(o_line), .O_frame_cnt(o_frame),
    .O_size_ok(o_ok), .O_odd_err(o_odd)
  );

  cmos_pixel_capture #(
    .FRAME_SKIP(2), .H_PIXELS(4), .V_LINES(3), .SWAP_RB(1'b0)
  ) dut0 (
    .cmos_pclk(clk), .I_rst_n(rst_n), .I_cfg_done(cfg_done), .I_vsync(vsync),
    .I_href(href), .I_data(data), .O_vs_n(o_vs_n0), .O_de(o_de0), .O_data(o_data0),
    .O_streaming(o_str0), .O_pix_cnt(o_pix0), .O_line_cnt(o_line0), .O_frame_cnt(o_frame0),
    .O_size_ok(o_ok0), .O_odd_err(o_odd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_de) de_count = de_count + 1;
    if (o_de && de_prev) consec = consec + 1;
    de_prev = o_de;
  end

  task automatic step(input logic v, input logic h, input logic [7:0] d);
    vsync = v;
    href  = h;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int nbytes, input int seed);
    for (int i = 0; i < nbytes; i++) step(1'b0, 1'b1, 8'(seed + i));
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int lines, input int nbytes, input int seed);
    for (int l = 0; l < lines; l++) send_line(nbytes, seed + l * 16);
    vsync_pulse();
  endtask

  task automatic test_reset();
    n_checks++; if (o_de !== 1'b0) begin n_fail++; $display("FAIL reset_de got %b want 0", o_de); end
    n_checks++; if (o_vs_n !== 1'b1) begin n_fail++; $display("FAIL reset_vs_n got %b want 1", o_vs_n); end
    n_checks++; if (o_data !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", o_data); end
    n_checks++; if (o_str !== 1'b0) begin n_fail++; $display("FAIL reset_streaming got %b want 0", o_str); end
    n_checks++; if (o_pix !== 12'd0) begin n_fail++; $display("FAIL reset_pix got %0d want 0", o_pix); end
    n_checks++; if (o_line !== 12'd0) begin n_fail++; $display("FAIL reset_line got %0d want 0", o_line); end
    n_checks++; if (o_frame !== 16'd0) begin n_fail++; $display("FAIL reset_frame got %0d want 0", o_frame); end
    n_checks++; if (o_ok !== 1'b0) begin n_fail++; $display("FAIL reset_size_ok got %b want 0", o_ok); end
    n_checks++; if (o_odd !== 1'b0) begin n_fail++; $display("FAIL reset_odd got %b want 0", o_odd); end
  endtask

  task automatic test_frame_skip();
    int base;
    cfg_done = 1'b1;
    repeat (4) step(1'b0, 1'b0, 8'h00);
    n_checks++; if (o_str !== 1'b0) begin n_fail++; $display("FAIL skip_not_streaming got %b want 0", o_str); end
    base = de_count;
    send_frame(3, 8, 8'h10);
    send_frame(3, 8, 8'h40);
    n_checks++; if (de_count !== base) begin n_fail++; $display("FAIL skip_no_de got %0d want %0d", de_count, base); end
    n_checks++; if (o_str !== 1'b1) begin n_fail++; $display("FAIL skip_armed got %b want 1", o_str); end
    send_frame(3, 8, 8'h20);
    send_frame(3, 8, 8'h30);
    n_checks++; if (o_frame !== 16'd2) begin n_fail++; $display("FAIL skip_frame_cnt got %0d want 2", o_frame); end
    n_checks++; if (o_line !== 12'd3) begin n_fail++; $display("FAIL skip_line_cnt got %0d want 3", o_line); end
    n_checks++; if (o_pix !== 12'd4) begin n_fail++; $display("FAIL skip_pix_cnt got %0d want 4", o_pix); end
    n_checks++; if (o_ok !== 1'b1) begin n_fail++; $display("FAIL skip_size_ok got %b want 1", o_ok); end
    n_checks++; if (de_count - base !== 24) begin n_fail++; $display("FAIL skip_de_total got %0d want 24", de_count - base); end
    n_checks++; if (consec !== 0) begin n_fail++; $display("FAIL de_back_to_back got %0d want 0", consec); end
  endtask

  task automatic pair_check(input logic [7:0] hi, input logic [7:0] lo, input logic [15:0] exp1,
                            input logic [15:0] exp0, input logic [11:0] pix_before);
    step(1'b0, 1'b1, hi);
    step(1'b0, 1'b1, lo);
    step(1'b0, 1'b0, 8'h00);
    n_checks++; if (o_de !== 1'b0) begin n_fail++; $display("FAIL pair_early_de got %b want 0", o_de); end
    step(1'b0, 1'b0, 8'h00);
    n_checks++; if (o_de !== 1'b1) begin n_fail++; $display("FAIL pair_de got %b want 1", o_de); end
    n_checks++; if (o_data !== exp1) begin n_fail++; $display("FAIL pair_swap1 got %h want %h", o_data, exp1); end
    n_checks++; if (o_data0 !== exp0) begin n_fail++; $display("FAIL pair_swap0 got %h want %h", o_data0, exp0); end
    n_checks++; if (o_pix !== pix_before) begin n_fail++; $display("FAIL pix_early got %0d want %0d", o_pix, pix_before); end
    step(1'b0, 1'b0, 8'h00);
    n_checks++; if (o_de !== 1'b0) begin n_fail++; $display("FAIL pair_one_cycle got %b want 0", o_de); end
    n_checks++; if (o_pix !== 12'd1) begin n_fail++; $display("FAIL pix_update got %0d want 1", o_pix); end
  endtask

  task automatic test_swizzle_and_vsync();
    pair_check(8'hF8, 8'h1F, 16'hF81F, 16'hF81F, 12'd4);
    pair_check(8'hF8, 8'h00, 16'h001F, 16'hF800, 12'd1);
    pair_check(8'h12, 8'h34, 16'hA222, 16'h1234, 12'd1);
    step(1'b1, 1'b0, 8'h00);
    n_checks++; if (o_vs_n !== 1'b1) begin n_fail++; $display("FAIL vs_n_d1 got %b want 1", o_vs_n); end
    step(1'b1, 1'b0, 8'h00);
    n_checks++; if (o_vs_n !== 1'b1) begin n_fail++; $display("FAIL vs_n_d2 got %b want 1", o_vs_n); end
    n_checks++; if (o_frame !== 16'd2) begin n_fail++; $display("FAIL frame_early got %0d want 2", o_frame); end
    step(1'b1, 1'b0, 8'h00);
    n_checks++; if (o_vs_n !== 1'b0) begin n_fail++; $display("FAIL vs_n_low got %b want 0", o_vs_n); end
    n_checks++; if (o_frame !== 16'd3) begin n_fail++; $display("FAIL frame_update got %0d want 3", o_frame); end
    n_checks++; if (o_line !== 12'd3) begin n_fail++; $display("FAIL swz_line got %0d want 3", o_line); end
    n_checks++; if (o_ok !== 1'b0) begin n_fail++; $display("FAIL swz_size_ok got %b want 0", o_ok); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    n_checks++; if (o_vs_n !== 1'b1) begin n_fail++; $display("FAIL vs_n_release got %b want 1", o_vs_n); end
  endtask

  task automatic test_odd_line();
    int base;
    base = de_count;
    send_line(9, 8'h50);
    n_checks++; if (o_odd !== 1'b1) begin n_fail++; $display("FAIL odd_set got %b want 1", o_odd); end
    send_line(8, 8'h60);
    send_line(8, 8'h70);
    vsync_pulse();
    n_checks++; if (de_count - base !== 12) begin n_fail++; $display("FAIL odd_de_count got %0d want 12", de_count - base); end
    n_checks++; if (o_ok !== 1'b0) begin n_fail++; $display("FAIL odd_size_ok got %b want 0", o_ok); end
    n_checks++; if (o_frame !== 16'd4) begin n_fail++; $display("FAIL odd_frame got %0d want 4", o_frame); end
    send_frame(3, 8, 8'h80);
    n_checks++; if (o_ok !== 1'b1) begin n_fail++; $display("FAIL odd_recover_ok got %b want 1", o_ok); end
    n_checks++; if (o_odd !== 1'b1) begin n_fail++; $display("FAIL odd_sticky got %b want 1", o_odd); end
  endtask

  task automatic test_geometry();
    send_frame(2, 8, 8'h90);
    n_checks++; if (o_line !== 12'd2) begin n_fail++; $display("FAIL geo_lines got %0d want 2", o_line); end
    n_checks++; if (o_ok !== 1'b0) begin n_fail++; $display("FAIL geo_short_ok got %b want 0", o_ok); end
    send_frame(3, 6, 8'hA0);
    n_checks++; if (o_pix !== 12'd3) begin n_fail++; $display("FAIL geo_pix got %0d want 3", o_pix); end
    n_checks++; if (o_line !== 12'd3) begin n_fail++; $display("FAIL geo_lines3 got %0d want 3", o_line); end
    n_checks++; if (o_ok !== 1'b0) begin n_fail++; $display("FAIL geo_narrow_ok got %b want 0", o_ok); end
    send_frame(3, 8, 8'hB0);
    n_checks++; if (o_ok !== 1'b1) begin n_fail++; $display("FAIL geo_good_ok got %b want 1", o_ok); end
    n_checks++; if (o_frame !== 16'd8) begin n_fail++; $display("FAIL geo_frame got %0d want 8", o_frame); end
  endtask

  task automatic test_cfg_loss();
    int snap;
    send_line(8, 8'hC0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(i));
    cfg_done = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(i + 4));
    n_checks++; if (o_de !== 1'b0) begin n_fail++; $display("FAIL cfg_loss_de got %b want 0", o_de); end
    snap = de_count;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(i + 7));
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    n_checks++; if (de_count !== snap) begin n_fail++; $display("FAIL cfg_loss_quiet got %0d want %0d", de_count, snap); end
    n_checks++; if (o_str !== 1'b0) begin n_fail++; $display("FAIL cfg_loss_state got %b want 0", o_str); end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(i));
    cfg_done = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(i + 4));
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    vsync_pulse();
    n_checks++; if (o_frame !== 16'd8) begin n_fail++; $display("FAIL cfg_loss_frame got %0d want 8", o_frame); end
    send_frame(3, 8, 8'hD0);
    n_checks++; if (de_count !== snap) begin n_fail++; $display("FAIL reskip_no_de got %0d want %0d", de_count, snap); end
    n_checks++; if (o_str !== 1'b1) begin n_fail++; $display("FAIL reskip_armed got %b want 1", o_str); end
    send_frame(3, 8, 8'hE0);
    n_checks++; if (o_frame !== 16'd9) begin n_fail++; $display("FAIL reskip_frame got %0d want 9", o_frame); end
    n_checks++; if (de_count - snap !== 12) begin n_fail++; $display("FAIL reskip_de got %0d want 12", de_count - snap); end
  endtask

  task automatic test_async_reset();
    send_line(8, 8'h11);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(i));
    #1 rst_n = 1'b0;
    #1;
    test_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
    send_frame(3, 8, 8'h21);
    send_frame(3, 8, 8'h31);
    n_checks++; if (o_frame !== 16'd0) begin n_fail++; $display("FAIL rst_reskip_frame got %0d want 0", o_frame); end
    send_frame(3, 8, 8'h41);
    n_checks++; if (o_frame !== 16'd1) begin n_fail++; $display("FAIL rst_restart_frame got %0d want 1", o_frame); end
    n_checks++; if (o_ok !== 1'b1) begin n_fail++; $display("FAIL rst_restart_ok got %b want 1", o_ok); end
    n_checks++; if (consec !== 0) begin n_fail++; $display("FAIL de_back_to_back_end got %0d want 0", consec); end
  endtask

  initial begin
    rst_n    = 1'b0;
    cfg_done = 1'b0;
    vsync    = 1'b0;
    href     = 1'b0;
    data     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 8'h00);
    test_frame_skip();
    test_swizzle_and_vsync();
    test_odd_line();
    test_geometry();
    test_cfg_loss();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
